// File: rtl/sm2tc_serial_arb_if.sv
// sm2tc_serial_arb_if: requester, result and status signals of the sign-magnitude arbiter
interface sm2tc_serial_arb_if #(parameter int N = 8);
   logic req0_valid, req0_ready, req1_valid, req1_ready;
   logic [N-1:0] req0_data, req1_data, out_data;
   logic out_valid, out_ready, out_id, busy;
   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, out_ready,
      input req0_ready, req1_ready, out_valid, out_data, out_id, busy
   );
   modport slave (
      input req0_valid, req0_data, req1_valid, req1_data, out_ready,
      output req0_ready, req1_ready, out_valid, out_data, out_id, busy
   );
endinterface

// File: rtl/sm2tc_serial_arb.sv
// sm2tc_serial_arb: two-requester round-robin bit-serial sign-magnitude to two's-complement converter
module sm2tc_serial_arb #(
   parameter int N = 8
) (
   input logic clk,
   input logic rst_n,
   sm2tc_serial_arb_if.slave bus
);
   localparam int IW = $clog2(N);
   typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;
   state_t state, state_nxt;
   logic [N-1:0] mag, res, res_nxt, sel, out_data;
   logic [IW-1:0] idx;
   logic sign, carry, t, id, last, grant, xfer, done;
   always_comb begin
      grant = (bus.req0_valid & bus.req1_valid) ? ~last : bus.req1_valid;
      xfer = rst_n & (state == IDLE) & (bus.req0_valid | bus.req1_valid);
      sel = grant ? bus.req1_data : bus.req0_data;
      t = mag[0] ^ sign;
      done = idx == IW'(N - 2);
      res_nxt = res;
      res_nxt[idx] = t ^ carry;
      res_nxt[N-1] = sign;
      state_nxt = xfer ? CONV
                : (state == CONV && done) ? HOLD
                : (state == HOLD && bus.out_ready) ? IDLE
                : state;
      bus.req0_ready = xfer & ~grant;
      bus.req1_ready = xfer & grant;
      bus.out_valid = state == HOLD;
      bus.busy = state != IDLE;
      bus.out_id = id;
      bus.out_data = out_data;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         mag <= '0;
         res <= '0;
         out_data <= '0;
         sign <= 1'b0;
         carry <= 1'b0;
         idx <= '0;
         id <= 1'b0;
         last <= 1'b1;
      end else begin
         state <= state_nxt;
         if (xfer) begin
            mag <= sel;
            sign <= sel[N-1];
            carry <= sel[N-1];
            idx <= '0;
            id <= grant;
         end
         // magnitude shifts down so its current bit is always at position 0
         if (state == CONV) begin
            mag <= mag >> 1;
            res <= res_nxt;
            carry <= t & carry;
            idx <= idx + 1'b1;
            if (done) out_data <= res_nxt;
         end
         if (state == HOLD && bus.out_ready) last <= id;
      end
   end
endmodule

// File: tb/tb_sm2tc_serial_arb.sv
// tb_sm2tc_serial_arb: directed scoreboard bench for the serial sign-magnitude arbiter
module tb_sm2tc_serial_arb;
   localparam int N = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int cyc = 0, vectors = 0, miscmp = 0, nxfer = 0, fv = 0, x = 0, n = 0;
   logic [N:0] exp_q[$];
   logic [N:0] e;
   int xq[$], xlog[$];
   logic p_v = 1'b0, p_r = 1'b0, p_id = 1'b0;
   logic [N-1:0] p_d = '0;
   logic [7:0] d_tab [4] = '{8'h05, 8'hFF, 8'h80, 8'h00};
   logic [7:0] e_tab [4] = '{8'h05, 8'h81, 8'h80, 8'h00};
   sm2tc_serial_arb_if #(.N(N)) bus ();
   sm2tc_serial_arb #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscmp++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask
   always @(negedge clk) begin
      if (rst_n) begin
         if ((bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready)) begin
            chk("single_grant", {31'd0, bus.req0_ready & bus.req1_ready}, 0);
            xq.push_back(cyc + 1);
            xlog.push_back(cyc + 1);
            nxfer++;
         end
         if (bus.busy) chk("ready_while_busy", {30'd0, bus.req0_ready, bus.req1_ready}, 0);
         if (p_v & ~p_r) chk("hold_stable", {bus.out_valid, bus.out_id, bus.out_data}, {1'b1, p_id, p_d});
         if (~p_v && exp_q.size() == 0) chk("spurious_valid", {31'd0, bus.out_valid}, 0);
         if (bus.out_valid & ~p_v) fv = cyc + 1;
         if (bus.out_valid && bus.out_ready && exp_q.size() != 0 && xq.size() != 0) begin
            e = exp_q.pop_front();
            x = xq.pop_front();
            chk("out_data", {24'd0, bus.out_data}, {24'd0, e[N-1:0]});
            chk("out_id", {31'd0, bus.out_id}, {31'd0, e[N]});
            chk("latency", fv - x, N);
         end
      end
      p_v = rst_n & bus.out_valid;
      p_r = bus.out_ready;
      p_id = bus.out_id;
      p_d = bus.out_data;
   end
   task automatic wait_xfer(input int target);
      for (int i = 0; i < 50 * N; i++) begin
         @(posedge clk);
         #1;
         if (nxfer >= target) return;
      end
      chk("xfer_timeout", nxfer, target);
   endtask
   task automatic wait_drain();
      for (int i = 0; i < 8 * N; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) return;
      end
      chk("drain_timeout", exp_q.size(), 0);
   endtask
   task automatic go(input logic v0, input logic v1, input logic [7:0] d0, input logic [7:0] d1, input int nx);
      int n0 = nxfer;
      bus.req0_data = d0;
      bus.req1_data = d1;
      bus.req0_valid = v0;
      bus.req1_valid = v1;
      wait_xfer(n0 + nx);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_data = 8'($urandom);
      bus.req1_data = 8'($urandom);
      wait_drain();
   endtask
   initial begin
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      bus.req0_data = 8'h00;
      bus.req1_data = 8'h00;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 0);
      chk("reset_outputs", {bus.out_valid, bus.out_id, bus.busy, bus.out_data}, 0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp_q.push_back({1'b0, 8'hFB});
      go(1'b1, 1'b0, 8'h85, 8'h00, 1);
      chk("idle_after_85", {31'd0, bus.busy}, 0);
      chk("data_hold_85", {24'd0, bus.out_data}, 8'hFB);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({i[0], e_tab[i]});
         go(~i[0], i[0], d_tab[i], d_tab[i], 1);
         chk("data_hold", {24'd0, bus.out_data}, {24'd0, e_tab[i]});
      end
      // last grant was requester 1, so the contended burst starts with 0
      exp_q.push_back({1'b0, 8'hFD});
      exp_q.push_back({1'b1, 8'h02});
      exp_q.push_back({1'b0, 8'hFD});
      exp_q.push_back({1'b1, 8'h02});
      n = xlog.size();
      go(1'b1, 1'b1, 8'h83, 8'h02, 4);
      for (int i = 1; i < 4; i++) chk("spacing", xlog[n + i] - xlog[n + i - 1], N + 1);
      bus.out_ready = 1'b0;
      exp_q.push_back({1'b0, 8'h81});
      n = nxfer;
      bus.req0_data = 8'hFF;
      bus.req0_valid = 1'b1;
      wait_xfer(n + 1);
      bus.req0_valid = 1'b0;
      bus.req0_data = 8'h5A;
      for (int i = 0; i < 4 * N && !bus.out_valid; i++) begin
         @(posedge clk);
         #1;
      end
      chk("hold_reached", {31'd0, bus.out_valid}, 1);
      exp_q.push_back({1'b1, 8'h00});
      bus.req1_data = 8'h00;
      bus.req1_valid = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      chk("hold_no_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 0);
      chk("hold_data", {bus.out_valid, bus.out_id, bus.out_data}, {1'b1, 1'b0, 8'h81});
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("hold_before_accept", {31'd0, bus.out_valid}, 1);
      @(negedge clk);
      chk("first_edge_accept", {31'd0, bus.out_valid}, 0);
      wait_xfer(n + 2);
      bus.req1_valid = 1'b0;
      wait_drain();
      exp_q.push_back({1'b0, 8'h00});
      go(1'b1, 1'b0, 8'h00, 8'h00, 1);
      n = nxfer;
      bus.req1_data = 8'h85;
      bus.req1_valid = 1'b1;
      wait_xfer(n + 1);
      bus.req1_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      xq.delete();
      chk("abort_state", {bus.out_valid, bus.busy, bus.out_id, bus.out_data}, 0);
      repeat (3 * N) @(posedge clk);
      #1;
      exp_q.push_back({1'b0, 8'h05});
      go(1'b1, 1'b1, 8'h05, 8'h83, 1);
      chk("post_reset_idle", {31'd0, bus.busy}, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got %0d miscompares", miscmp);
      $fatal(1);
   end
endmodule
